// File: rtl/wb_noc_initiator_ni_pkg.sv
// Flit format shared by the initiator NI, the target NI and the router:
// type codes, widths and request/response head field positions.
package wb_noc_initiator_ni_pkg;

  localparam int FLIT_W = 34;
  localparam int NODE_W = 4;
  localparam int TAG_W  = 3;

  localparam logic [1:0] FT_BODY = 2'b00;
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;

  localparam int HD_DST = 28;
  localparam int HD_SRC = 24;
  localparam int HD_WE  = 23;
  localparam int HD_ERR = 23;
  localparam int HD_SEL = 19;
  localparam int HD_TAG = 16;

  function automatic logic [31:0] req_head(input logic [NODE_W-1:0] dst,
                                           input logic [NODE_W-1:0] src,
                                           input logic              we,
                                           input logic [3:0]        sel,
                                           input logic [TAG_W-1:0]  tag);
    logic [31:0] h;
    h = '0;
    h[HD_DST +: NODE_W] = dst;
    h[HD_SRC +: NODE_W] = src;
    h[HD_WE]            = we;
    h[HD_SEL +: 4]      = sel;
    h[HD_TAG +: TAG_W]  = tag;
    return h;
  endfunction

endpackage

// File: rtl/wb_noc_initiator_ni_if.sv
// Wishbone slave bus plus router tx/rx flit channels of the initiator NI.
// slave = NI side, master = core/router side.
interface wb_noc_initiator_ni_if;
  import wb_noc_initiator_ni_pkg::*;

  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [31:0]       wbs_adr_i;
  logic [31:0]       wbs_dat_i;
  logic [3:0]        wbs_sel_i;
  logic              wbs_ack_o;
  logic              wbs_err_o;
  logic [31:0]       wbs_dat_o;
  logic [FLIT_W-1:0] tx_flit_o;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic [FLIT_W-1:0] rx_flit_i;
  logic              rx_valid_i;
  logic              rx_ready_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_ack_o, wbs_err_o, wbs_dat_o,
    output tx_flit_o, tx_valid_o,
    input  tx_ready_i,
    input  rx_flit_i, rx_valid_i,
    output rx_ready_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  wbs_ack_o, wbs_err_o, wbs_dat_o,
    input  tx_flit_o, tx_valid_o,
    output tx_ready_i,
    output rx_flit_i, rx_valid_i,
    input  rx_ready_o
  );

endinterface

// File: rtl/wb_noc_initiator_ni.sv
// Wishbone classic slave -> NoC request packet, waits for tagged response, then ack/err.
// Read: stb sampled -> ack 5 cycles later (write 6); tx flits held until tx_ready_i, rx only while waiting/idle.
module wb_noc_initiator_ni
  import wb_noc_initiator_ni_pkg::*;
#(
  parameter logic [NODE_W-1:0] NODE_ID  = '0,
  parameter int                DEST_LSB = 28,
  parameter int unsigned       TIMEOUT  = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_noc_initiator_ni_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_ADDR, S_DATA, S_WAIT_H, S_WAIT_D, S_TOUT, S_DONE
  } state_e;

  localparam logic [15:0] TOUT_CNT = 16'(TIMEOUT);

  state_e             r_state;
  logic [31:0]        r_adr;
  logic [31:0]        r_dat;
  logic [3:0]         r_sel;
  logic               r_we;
  logic [TAG_W-1:0]   r_tag;
  logic               r_err;
  logic [15:0]        r_cnt;
  logic [31:0]        r_rdat;
  logic               r_rx_rdy;

  state_e             w_state_nxt;
  logic               w_req;
  logic               w_rx_hs;
  logic [1:0]         w_rx_type;
  logic [TAG_W-1:0]   w_rx_tag;
  logic [15:0]        w_cnt_nxt;
  logic               w_tout;
  logic               w_tx_vld;
  logic [FLIT_W-1:0]  w_tx_flit;
  logic               w_done_live;

  assign w_req     = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign w_rx_hs   = bus.rx_valid_i & r_rx_rdy;
  assign w_rx_type = bus.rx_flit_i[FLIT_W-1 -: 2];
  assign w_rx_tag  = bus.rx_flit_i[HD_TAG +: TAG_W];
  // Timeout fires on the edge where the counter would reach TIMEOUT.
  assign w_cnt_nxt = r_cnt + 16'd1;
  assign w_tout    = (w_cnt_nxt == TOUT_CNT);

  always_comb begin
    w_state_nxt = r_state;
    w_tx_vld    = 1'b0;
    w_tx_flit   = '0;
    case (r_state)
      S_IDLE: if (w_req) w_state_nxt = S_HEAD;
      S_HEAD: begin
        w_tx_vld  = 1'b1;
        w_tx_flit = {FT_HEAD, req_head(r_adr[DEST_LSB +: NODE_W], NODE_ID, r_we, r_sel, r_tag)};
        if (bus.tx_ready_i) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        w_tx_vld  = 1'b1;
        w_tx_flit = {(r_we ? FT_BODY : FT_TAIL), r_adr};
        if (bus.tx_ready_i) w_state_nxt = r_we ? S_DATA : S_WAIT_H;
      end
      S_DATA: begin
        w_tx_vld  = 1'b1;
        w_tx_flit = {FT_TAIL, r_dat};
        if (bus.tx_ready_i) w_state_nxt = S_WAIT_H;
      end
      // Non-matching heads and all non-head flits are consumed and dropped here.
      S_WAIT_H: begin
        if (w_rx_hs && w_rx_type == FT_HEAD && w_rx_tag == r_tag) w_state_nxt = S_WAIT_D;
        else if (w_tout)                                            w_state_nxt = S_TOUT;
      end
      S_WAIT_D: begin
        if (w_rx_hs && w_rx_type == FT_TAIL) w_state_nxt = S_DONE;
        else if (w_tout)                     w_state_nxt = S_TOUT;
      end
      S_TOUT:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_adr    <= '0;
      r_dat    <= '0;
      r_sel    <= '0;
      r_we     <= 1'b0;
      r_tag    <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_rdat   <= '0;
      r_rx_rdy <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rx_rdy <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_WAIT_H) ||
                  (w_state_nxt == S_WAIT_D);
      if (r_state == S_IDLE && w_req) begin
        r_adr <= bus.wbs_adr_i;
        r_dat <= bus.wbs_dat_i;
        r_sel <= bus.wbs_sel_i;
        r_we  <= bus.wbs_we_i;
        r_err <= 1'b0;
      end
      if (w_state_nxt == S_WAIT_H && r_state != S_WAIT_H)
        r_cnt <= '0;
      else if (r_state == S_WAIT_H || r_state == S_WAIT_D)
        r_cnt <= w_cnt_nxt;
      if (r_state == S_WAIT_H && w_state_nxt == S_WAIT_D)
        r_err <= bus.rx_flit_i[HD_ERR];
      if (r_state == S_WAIT_D && w_state_nxt == S_DONE && !r_we)
        r_rdat <= bus.rx_flit_i[31:0];
      if (r_state == S_TOUT)
        r_err <= 1'b1;
      if (r_state == S_DONE)
        r_tag <= r_tag + 1'b1;
    end
  end

  // A master that dropped the cycle gets no completion; the response is still drained.
  assign w_done_live   = (r_state == S_DONE) && w_req;
  assign bus.wbs_ack_o  = w_done_live && !r_err;
  assign bus.wbs_err_o  = w_done_live && r_err;
  assign bus.wbs_dat_o  = r_rdat;
  assign bus.tx_valid_o = w_tx_vld;
  assign bus.tx_flit_o  = w_tx_flit;
  assign bus.rx_ready_o = r_rx_rdy;

endmodule
